// File: rtl/matrix_pkg.sv
// Shared types and default widths for the sequential 4x4 matrix multiplier.
package matrix_pkg;

  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned ACC_W_DEF  = 2 * DATA_W_DEF + 2;

  typedef logic [3:0][DATA_W_DEF-1:0] vec4_t;
  typedef logic [ACC_W_DEF-1:0]       acc_t;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    STREAM
  } state_t;

endpackage

// File: rtl/matrix_dot4.sv
// Combinational 4-term dot product. Operands are two's complement when
// MATRIX_MULT_SIGNED_EN is defined, unsigned otherwise.
module matrix_dot4
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic [3:0][DATA_W-1:0] a,
  input  logic [3:0][DATA_W-1:0] b,
  output logic [ACC_W-1:0]       dot
);

`ifdef MATRIX_MULT_SIGNED_EN
  logic signed [2*DATA_W-1:0] prod [4];

  always_comb begin
    dot = '0;
    for (int k = 0; k < 4; k++) begin
      prod[k] = (2*DATA_W)'($signed(a[k])) * (2*DATA_W)'($signed(b[k]));
      dot     = dot + ACC_W'(prod[k]);
    end
  end
`else
  logic [2*DATA_W-1:0] prod [4];

  always_comb begin
    dot = '0;
    for (int k = 0; k < 4; k++) begin
      prod[k] = (2*DATA_W)'(a[k]) * (2*DATA_W)'(b[k]);
      dot     = dot + ACC_W'(prod[k]);
    end
  end
`endif

endmodule

// File: rtl/matrix_4x4_mult_seq.sv
// Captures a 4x4 A (rows) and B (columns) set, then streams C = A x B row-major,
// one element per accepted beat. Signed arithmetic when MATRIX_MULT_SIGNED_EN is defined.
module matrix_4x4_mult_seq
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [3:0][DATA_W-1:0] aC1,
  input  logic [3:0][DATA_W-1:0] aC2,
  input  logic [3:0][DATA_W-1:0] aC3,
  input  logic [3:0][DATA_W-1:0] aC4,
  input  logic [3:0][DATA_W-1:0] bC1,
  input  logic [3:0][DATA_W-1:0] bC2,
  input  logic [3:0][DATA_W-1:0] bC3,
  input  logic [3:0][DATA_W-1:0] bC4,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [ACC_W-1:0]       c_out,
  output logic [1:0]             c_row,
  output logic [1:0]             c_col,
  output logic                   c_last
);

  state_t                  state_q;
  logic [3:0][DATA_W-1:0]  a_q [4];
  logic [3:0][DATA_W-1:0]  b_q [4];
  logic [3:0]              idx_q;
  logic [3:0]              sel_idx;
  logic                    ready_q;
  logic                    valid_q;
  logic                    last_q;
  logic [ACC_W-1:0]        c_q;
  logic [3:0][DATA_W-1:0]  a_sel;
  logic [3:0][DATA_W-1:0]  b_sel;
  logic [ACC_W-1:0]        dot;
  logic                    accept;

  // The dot product always targets the element registered at the next load:
  // C[0][0] while in FIRST, C[idx+1] while streaming.
  always_comb begin
    sel_idx = (state_q == STREAM) ? idx_q + 4'd1 : idx_q;
    a_sel   = a_q[sel_idx[3:2]];
    b_sel   = b_q[sel_idx[1:0]];
  end

  matrix_dot4 #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dot4 (
    .a   (a_sel),
    .b   (b_sel),
    .dot (dot)
  );

  assign accept = valid_q && ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      c_q     <= '0;
      idx_q   <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_in && ready_q) begin
            a_q     <= '{aC1, aC2, aC3, aC4};
            b_q     <= '{bC1, bC2, bC3, bC4};
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= FIRST;
          end
        end
        FIRST: begin
          c_q     <= dot;
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          state_q <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            if (idx_q == 4'd15) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q  <= idx_q + 4'd1;
              c_q    <= dot;
              last_q <= (idx_q == 4'd14);
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign c_out     = c_q;
  assign c_row     = idx_q[3:2];
  assign c_col     = idx_q[1:0];
  assign c_last    = last_q;

endmodule

// File: tb/tb_matrix_4x4_mult_seq.sv
// Scoreboard bench for matrix_4x4_mult_seq: directed sets push expected beats,
// a negedge monitor compares every presented element against the queue head.
module tb_matrix_4x4_mult_seq;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 26;

  typedef logic [3:0][DW-1:0] v4_t;
  typedef v4_t mat_t [4];
  typedef struct {
    logic [AW-1:0] c;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic          ready_out;
  v4_t           aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4;
  logic          valid_out;
  logic          ready_in;
  logic [AW-1:0] c_out;
  logic [1:0]    c_row;
  logic [1:0]    c_col;
  logic          c_last;

  int   vectors = 0;
  int   miscompares = 0;
  int   pops = 0;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  matrix_4x4_mult_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .aC1       (aC1),
    .aC2       (aC2),
    .aC3       (aC3),
    .aC4       (aC4),
    .bC1       (bC1),
    .bC2       (bC2),
    .bC3       (bC3),
    .bC4       (bC4),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .c_out     (c_out),
    .c_row     (c_row),
    .c_col     (c_col),
    .c_last    (c_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  // Monitor: while a result is held the head must match; it is popped on accept.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_valid: got valid_out=1 row=%0d col=%0d, expected no output",
                   c_row, c_col);
        end else begin
          e = exp_q[0];
          chk("c_out", 32'(c_out), 32'(e.c));
          chk("c_row", 32'(c_row), 32'(e.row));
          chk("c_col", 32'(c_col), 32'(e.col));
          chk("c_last", 32'(c_last), 32'(e.last));
          if (ready_in) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  function automatic mat_t uni(input logic [DW-1:0] v);
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) m[i][k] = v;
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) m[i][k] = (i == k) ? DW'(1) : DW'(0);
    return m;
  endfunction

  // Columns of B where B[k][j] = 4k + j + 1 (values 1..16 row-major).
  function automatic mat_t seq_cols();
    mat_t m;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) m[j][k] = DW'(4 * k + j + 1);
    return m;
  endfunction

  task automatic push_uniform(input logic [AW-1:0] v);
    for (int n = 0; n < 16; n++)
      exp_q.push_back('{c: v, row: 2'(n / 4), col: 2'(n % 4), last: (n == 15)});
  endtask

  // Identity x B: C[i][j] = B[i][j] = 4i + j + 1.
  task automatic push_seq();
    for (int n = 0; n < 16; n++)
      exp_q.push_back('{c: AW'(n + 1), row: 2'(n / 4), col: 2'(n % 4), last: (n == 15)});
  endtask

  task automatic send(input mat_t ar, input mat_t bc, input bit hold);
    int n = 0;
    aC1 = ar[0]; aC2 = ar[1]; aC3 = ar[2]; aC4 = ar[3];
    bC1 = bc[0]; bC2 = bc[1]; bC3 = bc[2]; bC4 = bc[3];
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready_out !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL capture_timeout: got ready_out=%0b, expected 1 within 100 cycles", ready_out);
    end
    @(posedge clk); #1;
    if (!hold) valid_in = 1'b0;
    chk("ready_low_in_first", 32'(ready_out), 32'd0);
    chk("valid_low_in_first", 32'(valid_out), 32'd0);
  endtask

  task automatic wait_pops(input int target, output int cycles);
    cycles = 0;
    while (pops < target && cycles < 300) begin
      @(posedge clk);
      cycles++;
    end
    #1;
    if (pops < target) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: got %0d beats, expected %0d", pops, target);
    end
  endtask

  task automatic check_done();
    chk("ready_back_after_last", 32'(ready_out), 32'd1);
    chk("valid_low_after_last", 32'(valid_out), 32'd0);
  endtask

  initial begin
    int base;
    int cyc;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    {aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4} = '0;
    #12;
    chk("rst_ready_out", 32'(ready_out), 32'd1);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_c_row", 32'(c_row), 32'd0);
    chk("rst_c_col", 32'(c_col), 32'd0);
    chk("rst_c_last", 32'(c_last), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Identity x (1..16): back-to-back beats, 17 edges from capture to last accept.
    base = pops;
    push_seq();
    send(ident(), seq_cols(), 1'b0);
    wait_pops(base + 16, cyc);
    chk("back_to_back_cycles", 32'(cyc), 32'd17);
    check_done();

    // All 2 x all 3: first result is visible one edge after FIRST.
    base = pops;
    push_uniform(AW'(24));
    send(uni(DW'(2)), uni(DW'(3)), 1'b0);
    @(posedge clk); #1;
    chk("first_valid", 32'(valid_out), 32'd1);
    chk("first_c_out", 32'(c_out), 32'd24);
    wait_pops(base + 16, cyc);
    check_done();

    // All-ones 12-bit operands.
    base = pops;
`ifdef MATRIX_MULT_SIGNED_EN
    push_uniform(AW'(4));
`else
    push_uniform(AW'(67076100));
`endif
    send(uni(DW'(4095)), uni(DW'(4095)), 1'b0);
    wait_pops(base + 16, cyc);
    check_done();

    // Backpressure at beat 5 (row 1, col 0) for 3 cycles.
    base = pops;
    push_seq();
    send(ident(), seq_cols(), 1'b0);
    wait_pops(base + 4, cyc);
    ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_c_row", 32'(c_row), 32'd1);
    chk("stall_c_col", 32'(c_col), 32'd0);
    chk("stall_c_out", 32'(c_out), 32'd5);
    ready_in = 1'b1;
    wait_pops(base + 16, cyc);
    check_done();
    chk("stall_beat_count", 32'(pops - base), 32'd16);

    // valid_in held through the stream with new inputs: only the captured set counts.
    base = pops;
    push_uniform(AW'(4));
    send(uni(DW'(1)), uni(DW'(1)), 1'b1);
    push_uniform(AW'(24));
    send(uni(DW'(2)), uni(DW'(3)), 1'b0);
    wait_pops(base + 32, cyc);
    check_done();

    // Reset pulsed at beat 7 aborts the stream.
    base = pops;
    push_seq();
    send(ident(), seq_cols(), 1'b0);
    wait_pops(base + 6, cyc);
    rst_n = 1'b0;
    #1;
    chk("abort_valid_out", 32'(valid_out), 32'd0);
    chk("abort_ready_out", 32'(ready_out), 32'd1);
    chk("abort_c_out", 32'(c_out), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    base = pops;
    push_seq();
    send(ident(), seq_cols(), 1'b0);
    wait_pops(base + 16, cyc);
    check_done();

`ifdef MATRIX_MULT_SIGNED_EN
    base = pops;
    push_uniform(AW'(4));
    send(uni(DW'(12'hFFF)), uni(DW'(12'hFFF)), 1'b0);
    wait_pops(base + 16, cyc);
    check_done();

    base = pops;
    push_uniform(26'h3FF_FFFC);
    send(uni(DW'(12'hFFF)), uni(DW'(1)), 1'b0);
    wait_pops(base + 16, cyc);
    check_done();
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
